// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared types for the fetch stage and IF/ID register
//   WORD_W        datapath width
//   word_t        one datapath word
//   fetch_state_t FETCH / HOLD / DROP fetch control states
//   ifid_t        IF/ID payload {instr, npc, valid}, also used for the skid entry
package fetch_stage_pkg;
   localparam int WORD_W = 32;
   typedef logic [WORD_W-1:0] word_t;
   typedef enum logic [1:0] {FETCH, HOLD, DROP} fetch_state_t;
   typedef struct packed {
      word_t instr;
      word_t npc;
      logic  valid;
   } ifid_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: PC block / icache / hazard unit / decode signals seen by the fetch stage
//   imemaddr, pc_plus_4        PC block -> fetch
//   iload, ihit                icache -> fetch
//   stall, flush               hazard/branch logic -> fetch
//   imemREN, pc_en             fetch -> icache / PC block
//   ifid_instr/npc/valid       fetch -> decode
interface fetch_stage_if #(parameter int WORD_W = fetch_stage_pkg::WORD_W);
   logic [WORD_W-1:0] imemaddr;
   logic [WORD_W-1:0] pc_plus_4;
   logic [WORD_W-1:0] iload;
   logic              ihit;
   logic              stall;
   logic              flush;
   logic              imemREN;
   logic              pc_en;
   logic [WORD_W-1:0] ifid_instr;
   logic [WORD_W-1:0] ifid_npc;
   logic              ifid_valid;
   modport slave (
      input  imemaddr, pc_plus_4, iload, ihit, stall, flush,
      output imemREN, pc_en, ifid_instr, ifid_npc, ifid_valid
   );
   modport master (
      output imemaddr, pc_plus_4, iload, ihit, stall, flush,
      input  imemREN, pc_en, ifid_instr, ifid_npc, ifid_valid
   );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch control and IF/ID pipeline register with 1-entry skid
//   CLK, RST   clock, synchronous active-high reset
//   bus        fetch_stage_if.slave: PC/icache/hazard inputs, imemREN/pc_en and IF/ID outputs
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter word_t BUBBLE_INSTR = '0
) (
   input logic           CLK,
   input logic           RST,
   fetch_stage_if.slave  bus
);
   localparam ifid_t BUBBLE = '{instr: BUBBLE_INSTR, npc: '0, valid: 1'b0};
   fetch_state_t state_q, state_d;
   ifid_t        ifid_q, ifid_d;
   ifid_t        skid_q, skid_d;
   ifid_t        fetched;
   assign fetched = '{instr: bus.iload, npc: bus.pc_plus_4, valid: 1'b1};
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= FETCH;
         ifid_q  <= BUBBLE;
         skid_q  <= BUBBLE;
      end else begin
         state_q <= state_d;
         ifid_q  <= ifid_d;
         skid_q  <= skid_d;
      end
   end
   always_comb begin
      state_d     = state_q;
      ifid_d      = ifid_q;
      skid_d      = skid_q;
      bus.imemREN = 1'b0;
      bus.pc_en   = 1'b0;
      case (state_q)
         FETCH: begin
            bus.imemREN = 1'b1;
            if (bus.flush) begin
               bus.pc_en = 1'b1;
               ifid_d    = BUBBLE;
               // a pending miss for the squashed address must be drained in DROP
               state_d   = bus.ihit ? FETCH : DROP;
            end else if (bus.ihit) begin
               bus.pc_en = 1'b1;
               if (bus.stall) begin
                  skid_d  = fetched;
                  state_d = HOLD;
               end else begin
                  ifid_d = fetched;
               end
            end else if (!bus.stall) begin
               ifid_d = BUBBLE;
            end
         end
         HOLD: begin
            if (bus.flush) begin
               bus.pc_en = 1'b1;
               skid_d    = BUBBLE;
               ifid_d    = BUBBLE;
               state_d   = FETCH;
            end else if (!bus.stall) begin
               ifid_d  = skid_q;
               skid_d  = BUBBLE;
               state_d = FETCH;
            end
         end
         DROP: begin
            bus.imemREN = 1'b1;
            ifid_d      = BUBBLE;
            bus.pc_en   = bus.flush;
            state_d     = (!bus.flush && bus.ihit) ? FETCH : DROP;
         end
         default: state_d = FETCH;
      endcase
      if (RST) begin
         bus.imemREN = 1'b0;
         bus.pc_en   = 1'b0;
      end
   end
   assign bus.ifid_instr = ifid_q.instr;
   assign bus.ifid_npc   = ifid_q.npc;
   assign bus.ifid_valid = ifid_q.valid;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage
module tb_fetch_stage;
   import fetch_stage_pkg::*;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   ifid_t sb[$];
   fetch_stage_if #(.WORD_W(32)) bus ();
   fetch_stage dut (.CLK(CLK), .RST(RST), .bus(bus.slave));
   always #5 CLK = ~CLK;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   // drive one cycle, check combinational outputs, then check IF/ID after the edge
   task automatic step(input logic rst, input logic ihit, input logic stall, input logic flush,
                       input logic [31:0] iload, input logic [31:0] pc4,
                       input logic exp_ren, input logic exp_pcen,
                       input logic [31:0] exp_instr, input logic exp_valid, input logic [31:0] exp_npc);
      ifid_t e;
      RST = rst;
      bus.ihit = ihit;
      bus.stall = stall;
      bus.flush = flush;
      bus.iload = iload;
      bus.pc_plus_4 = pc4;
      bus.imemaddr = pc4 - 32'd4;
      sb.push_back('{instr: exp_instr, npc: exp_npc, valid: exp_valid});
      #1;
      chk("imemREN", {31'd0, bus.imemREN}, {31'd0, exp_ren});
      chk("pc_en", {31'd0, bus.pc_en}, {31'd0, exp_pcen});
      @(posedge CLK);
      #1;
      e = sb.pop_front();
      chk("ifid_instr", bus.ifid_instr, e.instr);
      chk("ifid_valid", {31'd0, bus.ifid_valid}, {31'd0, e.valid});
      if (e.valid) chk("ifid_npc", bus.ifid_npc, e.npc);
   endtask
   initial begin
      bus.ihit = 1'b0;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      bus.iload = '0;
      bus.pc_plus_4 = '0;
      bus.imemaddr = '0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_valid", {31'd0, bus.ifid_valid}, 32'd0);
      chk("rst_instr", bus.ifid_instr, 32'd0);
      chk("rst_ren", {31'd0, bus.imemREN}, 32'd0);
      chk("rst_pcen", {31'd0, bus.pc_en}, 32'd0);
      RST = 1'b0;
      #1;
      chk("post_rst_ren", {31'd0, bus.imemREN}, 32'd1);
      // stream
      step(0, 1, 0, 0, 32'h20080001, 32'h4, 1, 1, 32'h20080001, 1, 32'h4);
      step(0, 1, 0, 0, 32'h20090002, 32'h8, 1, 1, 32'h20090002, 1, 32'h8);
      // stall with hit: one pc_en pulse, then HOLD with IF/ID frozen
      step(0, 1, 1, 0, 32'h8D2A0000, 32'hC, 1, 1, 32'h20090002, 1, 32'h8);
      step(0, 1, 1, 0, 32'h8D2A0000, 32'hC, 0, 0, 32'h20090002, 1, 32'h8);
      step(0, 1, 1, 0, 32'h8D2A0000, 32'hC, 0, 0, 32'h20090002, 1, 32'h8);
      step(0, 0, 0, 0, 32'h0, 32'h10, 0, 0, 32'h8D2A0000, 1, 32'hC);
      // flush on hit
      step(0, 1, 0, 1, 32'h11111111, 32'h10, 1, 1, 32'h0, 0, 32'h0);
      step(0, 1, 0, 0, 32'h00000020, 32'h14, 1, 1, 32'h00000020, 1, 32'h14);
      // flush on miss, squashed miss completes later
      step(0, 0, 0, 1, 32'h0, 32'h18, 1, 1, 32'h0, 0, 32'h0);
      step(0, 0, 0, 0, 32'h0, 32'h20, 1, 0, 32'h0, 0, 32'h0);
      step(0, 0, 0, 0, 32'h0, 32'h20, 1, 0, 32'h0, 0, 32'h0);
      step(0, 0, 0, 0, 32'h0, 32'h20, 1, 0, 32'h0, 0, 32'h0);
      step(0, 1, 0, 0, 32'hDEADBEEF, 32'h20, 1, 0, 32'h0, 0, 32'h0);
      step(0, 1, 0, 0, 32'h01234567, 32'h24, 1, 1, 32'h01234567, 1, 32'h24);
      // miss without stall -> bubble; miss with stall -> hold
      step(0, 0, 0, 0, 32'h0, 32'h28, 1, 0, 32'h0, 0, 32'h0);
      step(0, 1, 0, 0, 32'hAAAA0001, 32'h30, 1, 1, 32'hAAAA0001, 1, 32'h30);
      step(0, 0, 1, 0, 32'h0, 32'h34, 1, 0, 32'hAAAA0001, 1, 32'h30);
      // flush during HOLD discards the skid
      step(0, 1, 1, 0, 32'hBBBB0002, 32'h34, 1, 1, 32'hAAAA0001, 1, 32'h30);
      step(0, 0, 1, 1, 32'h0, 32'h40, 0, 1, 32'h0, 0, 32'h0);
      step(0, 1, 0, 0, 32'hCCCC0003, 32'h3C, 1, 1, 32'hCCCC0003, 1, 32'h3C);
      // flush in DROP stays in DROP
      step(0, 0, 0, 1, 32'h0, 32'h44, 1, 1, 32'h0, 0, 32'h0);
      step(0, 1, 0, 1, 32'hEEEE0000, 32'h50, 1, 1, 32'h0, 0, 32'h0);
      // reset while in DROP
      step(1, 0, 0, 0, 32'h0, 32'h50, 0, 0, 32'h0, 0, 32'h0);
      step(0, 1, 0, 0, 32'hFACE0004, 32'h54, 1, 1, 32'hFACE0004, 1, 32'h54);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
